// File: rtl/input_router_ctrl.sv
// Sequencer for the row routers: clears them, sweeps the scratchpad while any
// MPP FIFO wants data, then drains the MISO FIFOs in lockstep column pops.
module input_router_ctrl #(
    parameter int ROWS       = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_spad_max_addr,
    input  logic                  i_ag_valid,
    input  logic                  i_ag_done,
    input  logic [ROWS-1:0]       i_mpp_empty,
    input  logic [ROWS-1:0]       i_miso_empty,
    input  logic                  i_pe_ready,
    output logic                  o_reg_clear,
    output logic                  o_mpp_write_en,
    output logic                  o_spad_rd_en,
    output logic [ADDR_WIDTH-1:0] o_spad_rd_addr,
    output logic                  o_data_valid,
    output logic                  o_ac_en,
    output logic                  o_miso_pop_en,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;

    logic any_mpp_pending;
    logic all_mpp_empty;
    logic all_miso_ready;
    logic all_miso_empty;
    logic in_run;
    logic in_flow;

    assign any_mpp_pending = ~(&i_mpp_empty);
    assign all_mpp_empty   = &i_mpp_empty;
    assign all_miso_ready  = ~(|i_miso_empty);
    assign all_miso_empty  = &i_miso_empty;
    assign in_run          = (state == RUN);
    assign in_flow         = (state == RUN) || (state == DRAIN);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            // Leave RUN only once the last scratchpad read has been delivered.
            RUN:     if (i_ag_done && all_mpp_empty && !rd_valid) state_next = DRAIN;
            DRAIN:   if (all_miso_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wrap also guards against a counter left above a newly lowered max.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_addr <= '0;
        end else if (state == CLEAR) begin
            rd_addr <= '0;
        end else if (o_spad_rd_en) begin
            if (rd_addr >= i_spad_max_addr) begin
                rd_addr <= '0;
            end else begin
                rd_addr <= rd_addr + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= o_spad_rd_en;
        end
    end

    assign o_reg_clear    = (state == CLEAR);
    assign o_mpp_write_en = in_run && i_ag_valid && !i_ag_done;
    assign o_spad_rd_en   = in_run && any_mpp_pending;
    assign o_spad_rd_addr = rd_addr;
    assign o_data_valid   = rd_valid;
    assign o_ac_en        = rd_valid;
    assign o_miso_pop_en  = in_flow && i_pe_ready && all_miso_ready;
    assign o_busy         = (state != IDLE);
    assign o_done         = (state == DONE);

endmodule

// File: tb/tb_input_router_ctrl.sv
// Randomised directed passes through input_router_ctrl, checked every cycle
// against a pass-level behavioural model.
module tb_input_router_ctrl;

    localparam int ROWS = 4;
    localparam int AW   = 8;

    logic          i_clk = 1'b0;
    logic          i_nrst;
    logic          i_start;
    logic [AW-1:0] i_spad_max_addr;
    logic          i_ag_valid;
    logic          i_ag_done;
    logic [ROWS-1:0] i_mpp_empty;
    logic [ROWS-1:0] i_miso_empty;
    logic          i_pe_ready;
    logic          o_reg_clear;
    logic          o_mpp_write_en;
    logic          o_spad_rd_en;
    logic [AW-1:0] o_spad_rd_addr;
    logic          o_data_valid;
    logic          o_ac_en;
    logic          o_miso_pop_en;
    logic          o_busy;
    logic          o_done;

    input_router_ctrl #(.ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start),
        .i_spad_max_addr(i_spad_max_addr), .i_ag_valid(i_ag_valid),
        .i_ag_done(i_ag_done), .i_mpp_empty(i_mpp_empty),
        .i_miso_empty(i_miso_empty), .i_pe_ready(i_pe_ready),
        .o_reg_clear(o_reg_clear), .o_mpp_write_en(o_mpp_write_en),
        .o_spad_rd_en(o_spad_rd_en), .o_spad_rd_addr(o_spad_rd_addr),
        .o_data_valid(o_data_valid), .o_ac_en(o_ac_en),
        .o_miso_pop_en(o_miso_pop_en), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Model: which part of the pass we are in, how many reads the pass has
    // issued, and a queue of reads awaiting their one-cycle data return.
    typedef enum int {P_IDLE, P_CLEAR, P_RUN, P_DRAIN, P_DONE} phase_t;
    phase_t      phase = P_IDLE;
    int unsigned reads = 0;
    bit          in_flight[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clear"}, 32'(o_reg_clear), 0);
        check({tag, "_wr"},    32'(o_mpp_write_en), 0);
        check({tag, "_rd"},    32'(o_spad_rd_en), 0);
        check({tag, "_addr"},  32'(o_spad_rd_addr), 0);
        check({tag, "_dv"},    32'(o_data_valid), 0);
        check({tag, "_ac"},    32'(o_ac_en), 0);
        check({tag, "_pop"},   32'(o_miso_pop_en), 0);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_done"},  32'(o_done), 0);
    endtask

    // Inputs are already driven; compare this cycle, then advance one edge.
    task automatic cyc();
        bit exp_rd, exp_dv, exp_pop, exp_wr;
        int unsigned span;
        #1;
        exp_dv  = (in_flight.size() != 0) ? in_flight[0] : 1'b0;
        exp_rd  = (phase == P_RUN) && (i_mpp_empty != '1);
        exp_wr  = (phase == P_RUN) && i_ag_valid && !i_ag_done;
        exp_pop = (phase == P_RUN || phase == P_DRAIN) && i_pe_ready && (i_miso_empty == '0);
        span    = int'(i_spad_max_addr) + 1;
        check("busy",  32'(o_busy),         32'(phase != P_IDLE));
        check("clear", 32'(o_reg_clear),    32'(phase == P_CLEAR));
        check("done",  32'(o_done),         32'(phase == P_DONE));
        check("wr",    32'(o_mpp_write_en), 32'(exp_wr));
        check("rd",    32'(o_spad_rd_en),   32'(exp_rd));
        check("dv",    32'(o_data_valid),   32'(exp_dv));
        check("ac",    32'(o_ac_en),        32'(exp_dv));
        check("pop",   32'(o_miso_pop_en),  32'(exp_pop));
        if (exp_rd) check("addr", 32'(o_spad_rd_addr), reads % span);
        @(posedge i_clk);
        if (in_flight.size() != 0) void'(in_flight.pop_front());
        in_flight.push_back(exp_rd);
        if (exp_rd) reads++;
        case (phase)
            P_IDLE:  if (i_start) phase = P_CLEAR;
            P_CLEAR: begin phase = P_RUN; reads = 0; end
            P_RUN:   if (i_ag_done && i_mpp_empty == '1 && !exp_dv) phase = P_DRAIN;
            P_DRAIN: if (i_miso_empty == '1) phase = P_DONE;
            default: phase = P_IDLE;
        endcase
        #1;
    endtask

    task automatic idle_inputs();
        i_start = 0; i_ag_valid = 0; i_ag_done = 0;
        i_mpp_empty = '1; i_miso_empty = '1; i_pe_ready = 0;
    endtask

    task automatic random_run_inputs();
        i_start      = ($urandom_range(7) == 0);
        i_ag_valid   = 1'($urandom);
        i_ag_done    = 0;
        i_mpp_empty  = ROWS'($urandom);
        i_miso_empty = ($urandom_range(1) == 0) ? '0 : ROWS'($urandom);
        i_pe_ready   = 1'($urandom);
    endtask

    task automatic model_reset();
        phase = P_IDLE;
        reads = 0;
        in_flight.delete();
    endtask

    // Full pass: random RUN traffic, then completion, then a random MISO drain.
    task automatic run_pass(input logic [AW-1:0] max_addr, input int run_cycles);
        int guard;
        i_spad_max_addr = max_addr;
        idle_inputs();
        i_start = 1;
        cyc();
        i_start = 0;
        cyc();
        for (int i = 0; i < run_cycles; i++) begin
            random_run_inputs();
            cyc();
        end
        i_ag_done = 1; i_mpp_empty = '1; i_ag_valid = 1'($urandom);
        guard = 0;
        while (phase == P_RUN && guard < 8) begin cyc(); guard++; end
        check("reach_drain", 32'(phase == P_DRAIN), 1);
        for (int i = 0; i < 6; i++) begin
            i_miso_empty = ($urandom_range(1) == 0) ? '0 : ROWS'($urandom);
            if (i_miso_empty == '1) i_miso_empty = 4'b0001;
            i_pe_ready  = 1'($urandom);
            i_mpp_empty = ROWS'($urandom);
            i_start     = 1'($urandom);
            cyc();
        end
        i_miso_empty = '1; i_mpp_empty = '1; i_start = 0;
        guard = 0;
        while (phase != P_IDLE && guard < 8) begin cyc(); guard++; end
        check("pass_end", 32'(phase == P_IDLE), 1);
        i_ag_done = 0;
        cyc();
    endtask

    initial begin
        i_nrst = 0;
        i_spad_max_addr = '0;
        idle_inputs();
        #2;
        check_all_zero("rst");
        @(posedge i_clk); @(posedge i_clk); #1;
        i_nrst = 1;
        for (int i = 0; i < 3; i++) cyc();

        // Start, then a 10-cycle sweep with max 3 and lagging valid.
        i_spad_max_addr = 8'd3;
        i_start = 1;
        cyc();
        i_start = 0;
        check("clear_one", 32'(o_reg_clear), 1);
        cyc();
        for (int i = 0; i < 10; i++) begin
            i_mpp_empty = 4'b1011;
            i_ag_valid  = 1;
            cyc();
        end
        check("sweep_reads", reads, 10);
        i_mpp_empty = '1;

        // Pop gating on partial / stalled / ready MISO.
        i_miso_empty = 4'b0100; i_pe_ready = 1; cyc();
        i_miso_empty = 4'b0000; i_pe_ready = 0; cyc();
        i_miso_empty = 4'b0000; i_pe_ready = 1; cyc();

        // Completion with three drain pops, then a single done pulse.
        i_ag_done = 1; i_ag_valid = 1; i_miso_empty = 4'b0110;
        cyc();
        check("drain_entered", 32'(phase == P_DRAIN), 1);
        i_miso_empty = '0; i_pe_ready = 1;
        for (int i = 0; i < 3; i++) cyc();
        i_miso_empty = '1; i_pe_ready = 0;
        for (int i = 0; i < 3; i++) cyc();
        check("back_idle", 32'(o_busy), 0);
        idle_inputs();

        run_pass(8'd0, 12);
        run_pass(8'd5, 30);
        run_pass(8'(2 + $urandom_range(20)), 40);

        // Reset in RUN with every combinational strobe sensitised.
        i_spad_max_addr = 8'd7;
        i_start = 1; cyc(); i_start = 0; cyc();
        for (int i = 0; i < 5; i++) begin
            i_mpp_empty = 4'b0000; i_ag_valid = 1; i_miso_empty = '0; i_pe_ready = 1;
            cyc();
        end
        i_nrst = 0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge i_clk); #1;
        check("midrst_hold_done", 32'(o_done), 0);
        i_nrst = 1;
        idle_inputs();
        for (int i = 0; i < 3; i++) cyc();
        run_pass(8'd3, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
